myproject_sdiv_29s_13s_16_seq: RTL and testbench

Iterative signed divider, the inverse of the 16s x 13s -> 29 product path. It recovers a 16-bit signed quotient, plus a 13-bit signed remainder, from a 29-bit signed dividend and a 13-bit signed divisor. It produces one quotient bit per clock using restoring division on magnitudes, under a valid/ready handshake. It is used where a dequantisation or normalisation stage must undo a fixed-point scaling product.

---
 rtl/myproject_sdiv_29s_13s_16_seq.sv | 168 ++++++++++++++++
 tb/tb_myproject_sdiv_29s_13s_16_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_sdiv_29s_13s_16_seq.sv
// rtl/myproject_sdiv_29s_13s_16_seq.sv - iterative signed restoring divider, 29s / 13s -> 16s quotient + 13s remainder
module myproject_sdiv_29s_13s_16_seq #(
  parameter int din0_WIDTH = 29,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz,
  output logic                  dout_vld,
  input  logic                  dout_rdy
);

  localparam int CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(din0_WIDTH - 1);
  // Largest positive quotient magnitude, and largest negative quotient magnitude
  localparam logic [din0_WIDTH-1:0] QPOS_MAX = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] QNEG_MAX = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  r_state;
  logic                    r_din_rdy;
  logic                    r_dout_vld;
  logic [dout_WIDTH-1:0]   r_dout;
  logic [din1_WIDTH-1:0]   r_rem;
  logic                    r_ovf;
  logic                    r_dz;
  logic                    r_sign_n;   // dividend sign, also the remainder sign
  logic                    r_sign_q;   // quotient sign
  logic                    r_dz_pend;  // divisor was zero: finish on the next edge
  logic [din0_WIDTH-1:0]   r_dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [din1_WIDTH-1:0]   r_dvs;      // divisor magnitude
  logic [din1_WIDTH-1:0]   r_prem;     // partial remainder, always < divisor magnitude
  logic [CW-1:0]           r_cnt;

  logic [din0_WIDTH-1:0]   w_mag0;
  logic [din1_WIDTH-1:0]   w_mag1;
  logic [din1_WIDTH:0]     w_shift;
  logic                    w_ge;
  logic [din1_WIDTH-1:0]   w_diff;
  logic [din1_WIDTH-1:0]   w_next_prem;
  logic [din0_WIDTH-1:0]   w_next_dvd;
  logic [dout_WIDTH-1:0]   w_qout;
  logic                    w_qovf;
  logic [din1_WIDTH-1:0]   w_rem;

  assign din_rdy  = r_din_rdy;
  assign dout_vld = r_dout_vld;
  assign dout     = r_dout;
  assign rem      = r_rem;
  assign ovf      = r_ovf;
  assign dz       = r_dz;

  // Operand magnitudes; the most negative dividend maps to 2^(din0_WIDTH-1), which still fits unsigned
  assign w_mag0 = din0[din0_WIDTH-1] ? (~din0 + din0_WIDTH'(1)) : din0;
  assign w_mag1 = din1[din1_WIDTH-1] ? (~din1 + din1_WIDTH'(1)) : din1;

  // One restoring step: the difference fits din1_WIDTH bits whenever it is taken
  assign w_shift     = {r_prem, r_dvd[din0_WIDTH-1]};
  assign w_ge        = (w_shift >= {1'b0, r_dvs});
  assign w_diff      = w_shift[din1_WIDTH-1:0] - r_dvs;
  assign w_next_prem = w_ge ? w_diff : w_shift[din1_WIDTH-1:0];
  assign w_next_dvd  = {r_dvd[din0_WIDTH-2:0], w_ge};

  // Signed, saturated quotient and signed remainder from the final step's magnitudes
  always_comb begin
    w_qout = '0;
    w_qovf = 1'b0;
    if (r_sign_q) begin
      if (w_next_dvd > QNEG_MAX) begin
        w_qout = DOUT_MIN;
        w_qovf = 1'b1;
      end else begin
        w_qout = '0 - w_next_dvd[dout_WIDTH-1:0];
      end
    end else begin
      if (w_next_dvd > QPOS_MAX) begin
        w_qout = DOUT_MAX;
        w_qovf = 1'b1;
      end else begin
        w_qout = w_next_dvd[dout_WIDTH-1:0];
      end
    end
    w_rem = r_sign_n ? ('0 - w_next_prem) : w_next_prem;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= IDLE;
      r_din_rdy  <= 1'b1;
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
      r_dz       <= 1'b0;
      r_sign_n   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_dz_pend  <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (din_vld) begin
            r_din_rdy <= 1'b0;
            r_sign_n  <= din0[din0_WIDTH-1];
            r_sign_q  <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            r_dvd     <= w_mag0;
            r_dvs     <= w_mag1;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_dz_pend <= (din1 == '0);
            r_state   <= CALC;
          end
        end
        CALC: begin
          if (r_dz_pend) begin
            // Divide by zero saturates toward the dividend's sign
            r_dout     <= r_sign_n ? DOUT_MIN : DOUT_MAX;
            r_rem      <= '0;
            r_ovf      <= 1'b0;
            r_dz       <= 1'b1;
            r_dz_pend  <= 1'b0;
            r_dout_vld <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_dvd  <= w_next_dvd;
            r_prem <= w_next_prem;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
              r_dout     <= w_qout;
              r_rem      <= w_rem;
              r_ovf      <= w_qovf;
              r_dz       <= 1'b0;
              r_dout_vld <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          if (dout_rdy) begin
            r_dout_vld <= 1'b0;
            r_din_rdy  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_din_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_29s_13s_16_seq.sv
// tb/tb_myproject_sdiv_29s_13s_16_seq.sv - directed bench for the 29s/13s iterative divider
module tb_myproject_sdiv_29s_13s_16_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [28:0] din0;
  logic [12:0] din1;
  logic        din_vld;
  logic        din_rdy;
  logic [15:0] dout;
  logic [12:0] rem;
  logic        ovf;
  logic        dz;
  logic        dout_vld;
  logic        dout_rdy;

  int checks = 0;
  int errors = 0;

  myproject_sdiv_29s_13s_16_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .din0     (din0),
    .din1     (din1),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dz       (dz),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  always #5 ap_clk = ~ap_clk;

  // Sign vectors: dividend, divisor, quotient, remainder
  int sg_a[5] = '{-1000, 1000, -1000, 0, 100000};
  int sg_b[5] = '{7, -7, -7, 5, -4096};
  int sg_q[5] = '{-142, -142, 142, 0, -24};
  int sg_r[5] = '{-6, 6, -6, 0, 1696};

  // Saturation vectors: dividend, divisor, quotient, remainder, ovf
  int st_a[8] = '{268435455, -268435456, -268435456, -32768, 32767, -32769, 32768, 65535};
  int st_b[8] = '{1, 1, -1, 1, 1, 1, 1, 2};
  int st_q[8] = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, 32767};
  int st_r[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  int st_o[8] = '{1, 1, 1, 0, 0, 1, 1, 0};

  // Divide-by-zero vectors: dividend, quotient
  int dz_a[3] = '{500, -500, 0};
  int dz_q[3] = '{32767, -32768, 32767};

  // Present operands for one accept edge, then count edges until dout_vld (99 on timeout)
  task automatic run_op(input int a, input int b, output int lat);
    int w;
    w = 0;
    while (!din_rdy && w < 50) begin
      @(posedge ap_clk); #1;
      w++;
    end
    din0 = 29'(a);
    din1 = 13'(b);
    din_vld = 1'b1;
    @(posedge ap_clk); #1;
    din_vld = 1'b0;
    lat = 0;
    do begin
      @(posedge ap_clk); #1;
      lat++;
    end while (!dout_vld && lat < 40);
    if (!dout_vld) lat = 99;
  endtask

  task automatic release_result();
    dout_rdy = 1'b1;
    @(posedge ap_clk); #1;
    dout_rdy = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    din0 = '0;
    din1 = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if ({din_rdy, dout_vld, dout, rem, ovf, dz} !== {1'b1, 1'b0, 16'd0, 13'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b dout=%0d rem=%0d ovf=%b dz=%b want rdy=1 vld=0 dout=0 rem=0 ovf=0 dz=0",
               din_rdy, dout_vld, dout, rem, ovf, dz);
    end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    run_op(1000, 7, lat);
    checks++;
    if (lat !== 29) begin
      errors++;
      $display("FAIL basic_latency got %0d want 29", lat);
    end
    checks++;
    if ({dout, rem, ovf, dz} !== {16'd142, 13'd6, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got dout=%0d rem=%0d ovf=%b dz=%b want dout=142 rem=6 ovf=0 dz=0",
               $signed(dout), $signed(rem), ovf, dz);
    end
    release_result();
    checks++;
    if ({dout_vld, din_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL basic_handshake got vld=%b rdy=%b want vld=0 rdy=1", dout_vld, din_rdy);
    end
  endtask

  task automatic test_signs();
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(sg_a[i], sg_b[i], lat);
      checks++;
      if (lat !== 29 || dout !== 16'(sg_q[i]) || rem !== 13'(sg_r[i]) || ovf !== 1'b0 || dz !== 1'b0) begin
        errors++;
        $display("FAIL signs_%0d got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b want lat=29 dout=%0d rem=%0d ovf=0 dz=0",
                 i, lat, $signed(dout), $signed(rem), ovf, dz, sg_q[i], sg_r[i]);
      end
      release_result();
    end
  endtask

  task automatic test_saturation();
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(st_a[i], st_b[i], lat);
      checks++;
      if (lat !== 29 || dout !== 16'(st_q[i]) || rem !== 13'(st_r[i]) || ovf !== 1'(st_o[i]) || dz !== 1'b0) begin
        errors++;
        $display("FAIL sat_%0d got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b want lat=29 dout=%0d rem=%0d ovf=%0d dz=0",
                 i, lat, $signed(dout), $signed(rem), ovf, dz, st_q[i], st_r[i], st_o[i]);
      end
      release_result();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(dz_a[i], 0, lat);
      checks++;
      if (lat !== 1 || dout !== 16'(dz_q[i]) || rem !== 13'd0 || ovf !== 1'b0 || dz !== 1'b1) begin
        errors++;
        $display("FAIL divzero_%0d got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b want lat=1 dout=%0d rem=0 ovf=0 dz=1",
                 i, lat, $signed(dout), $signed(rem), ovf, dz, dz_q[i]);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(100, 3, lat);
    for (int i = 0; i < 10; i++) begin
      din_vld = i[0];
      din0 = 29'($urandom);
      din1 = 13'(i + 1);
      @(posedge ap_clk); #1;
      checks++;
      if ({dout_vld, din_rdy, dout, rem, ovf, dz} !== {1'b1, 1'b0, 16'd33, 13'd1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d got vld=%b rdy=%b dout=%0d rem=%0d ovf=%b dz=%b want vld=1 rdy=0 dout=33 rem=1 ovf=0 dz=0",
                 i, dout_vld, din_rdy, $signed(dout), $signed(rem), ovf, dz);
      end
    end
    din_vld = 1'b0;
    release_result();
    checks++;
    if ({dout_vld, din_rdy, dout, rem} !== {1'b0, 1'b1, 16'd33, 13'd1}) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b dout=%0d rem=%0d want vld=0 rdy=1 dout=33 rem=1",
               dout_vld, din_rdy, $signed(dout), $signed(rem));
    end
    run_op(-77, 5, lat);
    checks++;
    if (lat !== 29 || dout !== 16'hFFF1 || rem !== 13'h1FFE || ovf !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b want lat=29 dout=-15 rem=-2 ovf=0 dz=0",
               lat, $signed(dout), $signed(rem), ovf, dz);
    end
    release_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    din0 = 29'd1000;
    din1 = 13'd7;
    din_vld = 1'b1;
    @(posedge ap_clk); #1;
    din_vld = 1'b0;
    repeat (10) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({din_rdy, dout_vld, dout, rem, ovf, dz} !== {1'b1, 1'b0, 16'd0, 13'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b dout=%0d rem=%0d ovf=%b dz=%b want rdy=1 vld=0 dout=0 rem=0 ovf=0 dz=0",
               din_rdy, dout_vld, dout, rem, ovf, dz);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    repeat (35) begin
      @(posedge ap_clk); #1;
      if (dout_vld) break;
    end
    checks++;
    if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle got vld=%b rdy=%b want vld=0 rdy=1", dout_vld, din_rdy);
    end
    run_op(1000, 7, lat);
    checks++;
    if (lat !== 29 || dout !== 16'd142 || rem !== 13'd6 || ovf !== 1'b0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b want lat=29 dout=142 rem=6 ovf=0 dz=0",
               lat, $signed(dout), $signed(rem), ovf, dz);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got timeout want completion");
    $fatal(1);
  end

endmodule
